parity_gen: RTL and testbench



---
 rtl/parity_gen.sv | 93 +++++++++
 tb/tb_parity_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_gen.sv
// parity_gen: registered even/odd parity generator with ones-count side output.
// One pipeline register stage; outputs come straight from flops.
// Optional parity checker (chk_in, chk_err, err_cnt) is built when the
// macro PARITY_GEN_CHECK_EN is defined; the default build omits it.
module parity_gen #(
  parameter int unsigned WIDTH = 8,
  parameter bit          ODD   = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             a,
  input  logic                         in_valid,
  output logic                         parity,
  output logic                         out_valid,
  output logic [$clog2(WIDTH+1)-1:0]   ones_cnt
`ifdef PARITY_GEN_CHECK_EN
  ,
  input  logic                         chk_in,
  output logic                         chk_err,
  output logic [15:0]                  err_cnt
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic            parity_d;
  logic [CntW-1:0] ones_cnt_d;
  logic            parity_q;
  logic            out_valid_q;
  logic [CntW-1:0] ones_cnt_q;

  // Parity of the incoming word: XOR tree, inverted for odd parity.
  always_comb begin
    parity_d = (^a) ^ ODD;
  end

  // Population count of the incoming word.
  always_comb begin
    ones_cnt_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones_cnt_d = ones_cnt_d + CntW'(a[i]);
    end
  end

  // Result register: load on valid, otherwise hold data and drop the valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q    <= 1'b0;
      ones_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (in_valid) begin
      parity_q    <= parity_d;
      ones_cnt_q  <= ones_cnt_d;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign parity    = parity_q;
  assign ones_cnt  = ones_cnt_q;
  assign out_valid = out_valid_q;

`ifdef PARITY_GEN_CHECK_EN
  logic        mismatch;
  logic        chk_err_q;
  logic [15:0] err_cnt_q;

  // Expected parity disagrees with the computed value.
  always_comb begin
    mismatch = (chk_in != parity_d);
  end

  // Error flag aligned with out_valid; counter saturates and clears only on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_err_q <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else if (in_valid) begin
      chk_err_q <= mismatch;
      if (mismatch && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end else begin
      chk_err_q <= 1'b0;
    end
  end

  assign chk_err = chk_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_gen.sv
// tb_parity_gen: bench for parity_gen (WIDTH=8), one even and one odd instance
// sharing the same stimulus. Checker ports are exercised when
// PARITY_GEN_CHECK_EN is defined.
module tb_parity_gen;

  localparam int unsigned W = 8;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         in_valid = 1'b0;
  logic         chk_in   = 1'b0;
  logic [W-1:0] a        = '0;

  logic         par0, par1, ov0, ov1;
  logic [3:0]   cnt0, cnt1;
`ifdef PARITY_GEN_CHECK_EN
  logic         cerr0, cerr1;
  logic [15:0]  ecnt0, ecnt1;
`endif

  int n_chk = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       p0;
    logic       p1;
    logic [3:0] cnt;
    logic       cerr;
  } exp_t;

  exp_t        q[$];
  logic [15:0] err_model;

  always #5 clk = ~clk;

  parity_gen #(.WIDTH(W), .ODD(1'b0)) u_even (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .in_valid  (in_valid),
    .parity    (par0),
    .out_valid (ov0),
    .ones_cnt  (cnt0)
`ifdef PARITY_GEN_CHECK_EN
    ,
    .chk_in    (chk_in),
    .chk_err   (cerr0),
    .err_cnt   (ecnt0)
`endif
  );

  // Odd instance gets an inverted chk_in so its mismatches track the even one.
  parity_gen #(.WIDTH(W), .ODD(1'b1)) u_odd (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .in_valid  (in_valid),
    .parity    (par1),
    .out_valid (ov1),
    .ones_cnt  (cnt1)
`ifdef PARITY_GEN_CHECK_EN
    ,
    .chk_in    (~chk_in),
    .chk_err   (cerr1),
    .err_cnt   (ecnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input logic c);
    exp_t e;
    e.p0   = ^d;
    e.p1   = ~(^d);
    e.cnt  = 4'($countones(d));
    e.cerr = (c != (^d));
    return e;
  endfunction

  // Scoreboard push at every sampling edge; reset discards in-flight results.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      err_model <= 16'h0000;
    end else if (in_valid) begin
      q.push_back(model(a, chk_in));
      if ((chk_in != (^a)) && (err_model != 16'hFFFF)) err_model <= err_model + 16'd1;
    end
  end

  task automatic check_entry(input exp_t e);
    check("sb_par", par0, e.p0);
    check("sb_par_odd", par1, e.p1);
    check("sb_cnt", cnt0, e.cnt);
    check("sb_cnt_odd", cnt1, e.cnt);
`ifdef PARITY_GEN_CHECK_EN
    check("sb_chk_err", cerr0, e.cerr);
    check("sb_chk_err_odd", cerr1, e.cerr);
`endif
  endtask

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_par", par0, 0);
      check("rst_par_odd", par1, 0);
      check("rst_ovld", ov0, 0);
      check("rst_cnt", cnt0, 0);
`ifdef PARITY_GEN_CHECK_EN
      check("rst_chk_err", cerr0, 0);
      check("rst_err_cnt", ecnt0, 0);
`endif
    end else begin
      check("ovld", ov0, q.size() != 0);
      check("ovld_odd", ov1, q.size() != 0);
      if (q.size() != 0) begin
        check_entry(q.pop_front());
      end else begin
`ifdef PARITY_GEN_CHECK_EN
        check("idle_chk_err", cerr0, 0);
`endif
      end
`ifdef PARITY_GEN_CHECK_EN
      check("err_cnt", ecnt0, err_model);
      check("err_cnt_odd", ecnt1, err_model);
`endif
    end
  end

  // Single word with constant expectations, checked one edge after sampling.
  task automatic direct(input logic [W-1:0] d, input logic c, input logic ep,
                        input logic epo, input logic [3:0] ec);
    @(negedge clk);
    a        = d;
    chk_in   = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("dir_par", par0, ep);
    check("dir_par_odd", par1, epo);
    check("dir_cnt", cnt0, ec);
    check("dir_ovld", ov0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_par", par0, 0);
    check("idle_cnt", cnt0, 0);
    check("idle_ovld", ov0, 0);

    direct(8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
    direct(8'h01, 1'b1, 1'b1, 1'b0, 4'd1);
    direct(8'hFF, 1'b0, 1'b0, 1'b1, 4'd8);
    direct(8'h07, 1'b1, 1'b1, 1'b0, 4'd3);
    direct(8'h03, 1'b0, 1'b0, 1'b1, 4'd2);
    direct(8'h07, 1'b1, 1'b1, 1'b0, 4'd3);

    // Unknown data with no valid must leave the held result untouched.
    @(negedge clk);
    a = 'x;
    repeat (3) @(negedge clk);
    check("hold_par", par0, 1);
    check("hold_cnt", cnt0, 3);
    check("hold_ovld", ov0, 0);

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a        = W'(i);
      chk_in   = ^a;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted between edges while streaming.
    @(negedge clk);
    a        = 8'h5A;
    chk_in   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    a = 8'hC3;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_par", par0, 0);
    check("async_par_odd", par1, 0);
    check("async_ovld", ov0, 0);
    check("async_cnt", cnt0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    direct(8'h07, 1'b1, 1'b1, 1'b0, 4'd3);

`ifdef PARITY_GEN_CHECK_EN
    direct(8'h01, 1'b0, 1'b1, 1'b0, 4'd1);
    check("chk_err_set", cerr0, 1);
    check("err_cnt_one", ecnt0, 1);
    direct(8'h01, 1'b1, 1'b1, 1'b0, 4'd1);
    check("chk_err_clr", cerr0, 0);
    check("err_cnt_keep", ecnt0, 1);
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      a        = 8'h01;
      chk_in   = 1'b0;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("err_cnt_sat", ecnt0, 16'hFFFF);
    check("err_cnt_sat_odd", ecnt1, 16'hFFFF);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
